// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite transfer, response and burst encodings
package ahb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, NONSEQ = 2'd2, SEQ = 2'd3} htrans_e;
  localparam logic OKAY  = 1'b0;
  localparam logic ERROR = 1'b1;
  localparam logic [2:0] SINGLE = 3'd0;
  localparam logic [2:0] INCR   = 3'd1;
  localparam logic [2:0] INCR4  = 3'd3;
  localparam logic [2:0] INCR8  = 3'd5;
  localparam logic [2:0] INCR16 = 3'd7;
  function automatic logic is_active(input logic [1:0] t);
    return t == NONSEQ || t == SEQ;
  endfunction
endpackage

// File: rtl/ahb_sram_mem.sv
// ahb_sram_mem: flop word array, one sync write port, one comb read port
module ahb_sram_mem #(
  parameter int DEPTH = 64,
  parameter int DATAW = 256,
  localparam int IW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_we,
  input  logic [IW-1:0]    i_waddr,
  input  logic [DATAW-1:0] i_wdata,
  input  logic [IW-1:0]    i_raddr,
  output logic [DATAW-1:0] o_rdata
);
  logic [DATAW-1:0] r_mem [DEPTH];
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_mem <= '{default: '0};
    else if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite responder over a flop word memory with wait states and range errors
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int ADDRW       = 32,
  parameter int DATAW       = 256,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hsel,
  input  logic [ADDRW-1:0] haddr,
  input  logic [1:0]       htrans,
  input  logic             hwrite,
  input  logic [2:0]       hsize,
  input  logic [2:0]       hburst,
  input  logic [DATAW-1:0] hwdata,
  output logic             hready,
  output logic             hresp,
  output logic [DATAW-1:0] hrdata
);
  localparam int LSB = $clog2(DATAW / 8);
  localparam int IW  = $clog2(DEPTH);
  localparam logic [ADDRW-1:0] DEPTH_A = ADDRW'(DEPTH);
  localparam logic [1:0] S_READY = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_ERR   = 2'd2;
  logic [1:0]       r_state;
  logic [3:0]       r_cnt;
  logic [IW-1:0]    r_idx;
  logic             r_write;
  logic             r_dp;
  logic             r_errc;
  logic [ADDRW-1:0] w_word;
  logic             w_oor;
  logic             w_acc;
  logic             w_done;
  logic [DATAW-1:0] w_rd;
  logic             w_unused;
  assign w_word   = haddr >> LSB;
  assign w_oor    = w_word >= DEPTH_A;
  assign w_acc    = hready && hsel && is_active(htrans);
  assign w_done   = r_state == S_READY && r_dp;
  assign hready   = r_state == S_READY;
  assign hresp    = (r_state == S_ERR || r_errc) ? ERROR : OKAY;
  assign hrdata   = (w_done && !r_write) ? w_rd : '0;
  assign w_unused = ^{hsize, hburst};
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state <= S_READY;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_write <= 1'b0;
      r_dp    <= 1'b0;
      r_errc  <= 1'b0;
    end else begin
      case (r_state)
        S_READY: begin
          r_errc <= 1'b0;
          r_dp   <= w_acc && !w_oor;
          if (w_acc) begin
            r_idx   <= w_word[IW-1:0];
            r_write <= hwrite;
            r_cnt   <= 4'(WAIT_CYCLES);
            r_state <= w_oor ? S_ERR : (WAIT_CYCLES > 0 ? S_WAIT : S_READY);
          end
        end
        S_WAIT: begin
          r_cnt   <= r_cnt - 4'd1;
          r_state <= r_cnt == 4'd1 ? S_READY : S_WAIT;
        end
        S_ERR: begin
          r_errc  <= 1'b1;
          r_state <= S_READY;
        end
        default: r_state <= S_READY;
      endcase
    end
  ahb_sram_mem #(.DEPTH(DEPTH), .DATAW(DATAW)) u_mem (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_done && r_write),
    .i_waddr (r_idx),
    .i_wdata (hwdata),
    .i_raddr (r_idx),
    .o_rdata (w_rd)
  );
endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave: directed checks on a zero-wait and a two-wait instance sharing one bus
module tb_ahb_sram_slave;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         hsel0 = 1'b0, hsel2 = 1'b0;
  logic [31:0]  haddr = '0;
  logic [1:0]   htrans = 2'd0;
  logic         hwrite = 1'b0;
  logic [2:0]   hsize = 3'd5;
  logic [2:0]   hburst = 3'd0;
  logic [255:0] hwdata = '0;
  logic         hready0, hresp0, hready2, hresp2;
  logic [255:0] hrdata0, hrdata2;
  logic [255:0] pat;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  ahb_sram_slave #(.WAIT_CYCLES(0)) u0 (
    .clk(clk), .rst(rst), .hsel(hsel0), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .hburst(hburst), .hwdata(hwdata), .hready(hready0), .hresp(hresp0), .hrdata(hrdata0));
  ahb_sram_slave #(.WAIT_CYCLES(2)) u2 (
    .clk(clk), .rst(rst), .hsel(hsel2), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .hburst(hburst), .hwdata(hwdata), .hready(hready2), .hresp(hresp2), .hrdata(hrdata2));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic addr(input logic [31:0] a, input logic [1:0] t, input logic w);
    haddr = a;
    htrans = t;
    hwrite = w;
  endtask

  initial begin
    pat = {8{32'hA5A5_0001}};
    repeat (3) tick;
    chk("rst_hready0", hready0, 1);
    chk("rst_hresp0", hresp0, 0);
    chk("rst_hrdata0", hrdata0, 0);
    chk("rst_hready2", hready2, 1);
    chk("rst_hrdata2", hrdata2, 0);
    rst = 1'b1;
    tick;
    hsel2 = 1'b1;
    addr(32'h0, 2'd2, 1'b0);
    tick;
    addr(32'h0, 2'd0, 1'b0);
    chk("rd0_w1", hready2, 0);
    tick;
    chk("rd0_w2", hready2, 0);
    tick;
    chk("rd0_rdy", hready2, 1);
    chk("rd0_data", hrdata2, 0);
    tick;
    addr(32'h40, 2'd2, 1'b1);
    tick;
    addr(32'h0, 2'd0, 1'b0);
    hwdata = pat;
    chk("wr40_w1", hready2, 0);
    tick;
    chk("wr40_w2", hready2, 0);
    tick;
    chk("wr40_rdy", hready2, 1);
    chk("wr40_resp", hresp2, 0);
    tick;
    hwdata = '0;
    addr(32'h40, 2'd2, 1'b0);
    tick;
    addr(32'h0, 2'd0, 1'b0);
    chk("rd40_w1", hready2, 0);
    tick;
    chk("rd40_w2", hready2, 0);
    tick;
    chk("rd40_rdy", hready2, 1);
    chk("rd40_resp", hresp2, 0);
    chk("rd40_data", hrdata2, pat);
    tick;
    addr(32'h800, 2'd2, 1'b1);
    tick;
    addr(32'h0, 2'd0, 1'b0);
    hwdata = 256'hBAD;
    chk("err1_resp", hresp2, 1);
    chk("err1_rdy", hready2, 0);
    tick;
    chk("err2_resp", hresp2, 1);
    chk("err2_rdy", hready2, 1);
    tick;
    chk("err3_resp", hresp2, 0);
    chk("err3_rdy", hready2, 1);
    hwdata = '0;
    addr(32'h0, 2'd2, 1'b0);
    tick;
    addr(32'h0, 2'd0, 1'b0);
    tick;
    tick;
    chk("nowrap_data", hrdata2, 0);
    tick;
    hsel2 = 1'b0;
    hsel0 = 1'b1;
    hburst = 3'd3;
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) addr(32'(i * 32), i == 0 ? 2'd2 : 2'd3, 1'b1);
      else addr(32'h0, 2'd0, 1'b0);
      hwdata = 256'(i);
      chk($sformatf("incr4_wr_rdy%0d", i), hready0, 1);
      tick;
    end
    hwdata = '0;
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) addr(32'(i * 32), i == 0 ? 2'd2 : 2'd3, 1'b0);
      else addr(32'h0, 2'd0, 1'b0);
      chk($sformatf("incr4_rd_rdy%0d", i), hready0, 1);
      if (i > 0) chk($sformatf("incr4_rd%0d", i), hrdata0, 256'(i));
      tick;
    end
    hburst = 3'd0;
    addr(32'h20, 2'd2, 1'b1);
    tick;
    addr(32'h20, 2'd2, 1'b0);
    hwdata = 256'hDEAD;
    tick;
    addr(32'h0, 2'd0, 1'b0);
    hwdata = '0;
    chk("pipe_rdy", hready0, 1);
    chk("pipe_data", hrdata0, 256'hDEAD);
    tick;
    hsel0 = 1'b0;
    hsel2 = 1'b1;
    addr(32'h60, 2'd2, 1'b1);
    tick;
    addr(32'h0, 2'd0, 1'b0);
    hwdata = 256'h1234;
    chk("rstw_wait", hready2, 0);
    #2 rst = 1'b0;
    #1;
    chk("rstw_rdy", hready2, 1);
    chk("rstw_resp", hresp2, 0);
    tick;
    rst = 1'b1;
    hwdata = '0;
    tick;
    addr(32'h60, 2'd2, 1'b0);
    tick;
    addr(32'h0, 2'd0, 1'b0);
    tick;
    tick;
    chk("rstw_rdy2", hready2, 1);
    chk("rstw_data", hrdata2, 0);
    tick;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ahb_sram_slave.md
# ahb_sram_slave

AHB-Lite responder fronting a flop-based word memory; the counterpart of the team's AHB burst master on the same bus. Accepts single, INCR and fixed-length INCR bursts beat by beat and inserts a configurable number of wait states per beat. Returns an ERROR response for out-of-range addresses. Serves as the bench target for master verification and as a small on-chip scratch RAM.

## Interface

Parameters:
- ADDRW, 32, address width
- DATAW, 256, data width; one beat = one full word of DATAW/8 bytes
- DEPTH, 64, number of memory words (power of two)
- WAIT_CYCLES, 0, wait states inserted per accepted NONSEQ/SEQ beat (0..15)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- hsel  in  1  slave select
- haddr  in  ADDRW  byte address
- htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
- hwrite  in  1  1=write
- hsize  in  3  accepted, not decoded (full-word beats only)
- hburst  in  3  accepted, not decoded (beats handled independently)
- hwdata  in  DATAW  write data, data phase
- hready  out  1  transfer complete / slave ready
- hresp  out  1  0=OKAY, 1=ERROR
- hrdata  out  DATAW  read data, data phase

## Operation

- Word index = haddr >> log2(DATAW/8); low byte-offset bits ignored. Out of range when word index >= DEPTH (all upper bits checked, no wrap).
- Address phase accepted on a rising edge with hready=1, hsel=1, htrans in {NONSEQ, SEQ}. Registers: word index, hwrite, and error flag.
- IDLE/BUSY, or hsel=0: no data phase; next cycle hready=1, hresp=0.
- FSM states: S_READY, S_WAIT, S_ERR.
  - S_READY: hready=1, hresp=0. On a valid accept: S_ERR if out of range, else S_WAIT if WAIT_CYCLES>0 (load wait counter to WAIT_CYCLES), else remain in S_READY (zero-wait data phase next cycle).
  - S_WAIT: hready=0, hresp=0; counter decrements each cycle; at 1 go to S_READY, whose first cycle completes the beat.
  - S_ERR: hready=0, hresp=1 for one cycle, then S_READY with hresp=1, hready=1 for the completing cycle (two-cycle ERROR response). Address phases presented while hready=0 are ignored.
- Write commit: mem[index_q] <= hwdata on the completing edge (data phase, hready=1, no error). Errored writes never modify memory.
- Read: hrdata = mem[index_q] during the completing cycle of a read data phase; 0 otherwise.
- Pipelined write to A followed by read of A: read data phase follows the write commit and returns new data.
- Wait counter width: 4 bits; no overflow possible.

## Timing

- Reset values: hready=1, hresp=0, hrdata=0, FSM=S_READY, counter=0, memory all zero.
- Latency: data phase completes WAIT_CYCLES+1 cycles after the address-phase edge. Error completes 2 cycles after it.
- Back-to-back beats at WAIT_CYCLES=0: one beat per cycle, hready held 1.
- Reset mid-operation (any state): outputs return to reset values asynchronously; a pending write is discarded.

## Structure

- Shared package ahb_pkg: htrans enum (IDLE, BUSY, NONSEQ, SEQ), hresp constants (OKAY, ERROR), hburst codes (SINGLE, INCR, INCR4, INCR8, INCR16). The master also moves to these definitions.
- Sub-module ahb_sram_mem: DEPTH x DATAW flop array, one synchronous write port, one combinational read port, async active-low clear.

## Test plan

- Reset: hold rst=0 for 3 cycles -> hready=1, hresp=0, hrdata=0; reads of word 0 return 0.
- WAIT_CYCLES=2, NONSEQ write 0x40 data {8{32'hA5A5_0001}}, then read 0x40 -> each beat has hready=0 for 2 cycles, then 1; read returns the written word, hresp=0.
- INCR4 write at 0x0 (0x0, 0x20, 0x40, 0x60, data 1..4), then INCR4 read, WAIT_CYCLES=0 -> hready constant 1; reads return 1, 2, 3, 4.
- Write to haddr=DEPTH*32 (0x800) -> hresp=1/hready=0, then hresp=1/hready=1, then hresp=0; word 0 still 0 (no wrap).
- Pipelined write 0x20 = 0xDEAD then read 0x20 with the address phase overlapping the write data phase -> read returns 0xDEAD.
- rst pulsed low during S_WAIT of a write to 0x60 -> hready=1 immediately; subsequent read of 0x60 returns 0.
